// File: rtl/elastic_pipeline_register_pkg.sv
// Shared types for the elastic pipeline register: state encoding and occupancy width.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/elastic_pipeline_register_sat_counter.sv
// Saturating up-counter with increment enable; cleared only by the async reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Flushable valid/ready pipeline register with a 2-entry skid buffer (main + skid).
// Optional stall/flush perf counters are enabled by defining PIPE_REG_PERF_EN.
module elastic_pipeline_register
    import pipe_reg_pkg::*;
#(
    parameter int DATA_W = 96,
`ifdef PIPE_REG_PERF_EN
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W = 16
`else
    parameter bit CLEAR_ON_FLUSH = 1'b1
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              flush_pulse,
`ifdef PIPE_REG_PERF_EN
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`else
    output logic [OCC_W-1:0]  occupancy
`endif
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              flush_pulse_q;
    logic              in_fire, out_fire;

    // Handshake outputs decode purely from the state register: no comb path from out_ready.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = '0;
        unique case (state_q)
            ST_EMPTY: ;
            ST_BUSY: begin
                out_valid = 1'b1;
                occupancy = OCC_W'(1);
            end
            ST_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = OCC_W'(2);
            end
            default: ;
        endcase
    end

    assign in_fire  = in_valid & in_ready & ~reset;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = in_data;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides any same-cycle acceptance; a same-cycle out_fire already completed.
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            flush_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            flush_pulse_q <= flush;
        end
    end

    assign out_data    = main_q;
    assign flush_pulse = flush_pulse_q;

`ifdef PIPE_REG_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (out_valid & ~out_ready),
        .count_o (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (flush),
        .count_o (flush_count)
    );
`else
`endif

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_elastic_pipeline_register;

    localparam int DATA_W = 96;
    typedef logic [DATA_W-1:0] word_t;

`ifdef PIPE_REG_PERF_EN
    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    word_t       in_data;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic        flush_pulse;
    logic [1:0]  occupancy;
`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    elastic_pipeline_register #(
        .DATA_W         (DATA_W),
`ifdef PIPE_REG_PERF_EN
        .CLEAR_ON_FLUSH (1'b1),
        .CNT_W          (CNT_W)
`else
        .CLEAR_ON_FLUSH (1'b1)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .flush_pulse  (flush_pulse),
`ifdef PIPE_REG_PERF_EN
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`else
        .occupancy    (occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register is a FIFO of depth 2 whose contents are the queue.
    word_t mq[$];
    logic  m_pulse;
`ifdef PIPE_REG_PERF_EN
    int    m_stall;
    int    m_fcnt;
`endif

    always @(posedge clk or posedge reset) begin
        bit infire;
        bit outfire;
        if (reset) begin
            mq.delete();
            m_pulse <= 1'b0;
`ifdef PIPE_REG_PERF_EN
            m_stall <= 0;
            m_fcnt  <= 0;
`endif
        end else begin
            infire  = in_valid && (mq.size() < 2);
            outfire = (mq.size() > 0) && out_ready;
`ifdef PIPE_REG_PERF_EN
            if ((mq.size() > 0) && !out_ready && (m_stall < CNT_MAX)) m_stall <= m_stall + 1;
            if (flush && (m_fcnt < CNT_MAX)) m_fcnt <= m_fcnt + 1;
`endif
            if (outfire) void'(mq.pop_front());
            if (infire) mq.push_back(in_data);
            if (flush) mq.delete();
            m_pulse <= flush;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("out_valid", word_t'(out_valid), word_t'(mq.size() > 0));
            check("in_ready", word_t'(in_ready), word_t'(mq.size() < 2));
            check("occupancy", word_t'(occupancy), word_t'(mq.size()));
            check("flush_pulse", word_t'(flush_pulse), word_t'(m_pulse));
            if (mq.size() > 0) check("out_data", out_data, mq[0]);
`ifdef PIPE_REG_PERF_EN
            check("stall_cycles", word_t'(stall_cycles), word_t'(m_stall));
            check("flush_count", word_t'(flush_count), word_t'(m_fcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", word_t'(out_valid), '0);
        check("rst_in_ready", word_t'(in_ready), word_t'(1));
        check("rst_out_data", out_data, '0);
        check("rst_occupancy", word_t'(occupancy), '0);
        check("rst_flush_pulse", word_t'(flush_pulse), '0);
        chk_en = 1'b1;

        // Streaming with out_ready high: one transfer per cycle, 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = word_t'(32'hA + i);
            tick();
            check("stream_valid", word_t'(out_valid), word_t'(1));
            check("stream_data", out_data, word_t'(32'hA + i));
            check("stream_in_ready", word_t'(in_ready), word_t'(1));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", word_t'(out_valid), '0);

        // Back-pressure fills main and skid, then drains in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word_t'(32'h11);
        tick();
        in_data   = word_t'(32'h22);
        tick();
        in_valid  = 1'b0;
        check("full_occ", word_t'(occupancy), word_t'(2));
        check("full_in_ready", word_t'(in_ready), '0);
        check("full_head", out_data, word_t'(32'h11));
        out_ready = 1'b1;
        tick();
        check("drain_first", out_data, word_t'(32'h22));
        check("drain_occ1", word_t'(occupancy), word_t'(1));
        tick();
        check("drain_occ0", word_t'(occupancy), '0);

        // Flush while FULL with a competing input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word_t'(32'h44);
        tick();
        in_data   = word_t'(32'h55);
        tick();
        flush     = 1'b1;
        in_data   = word_t'(32'h33);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush_occ", word_t'(occupancy), '0);
        check("flush_valid", word_t'(out_valid), '0);
        check("flush_pulse_hi", word_t'(flush_pulse), word_t'(1));
        check("flush_cleared", out_data, '0);
        tick();
        check("flush_pulse_lo", word_t'(flush_pulse), '0);
        check("flush_no_33", word_t'(out_valid), '0);

        // Flush while BUSY with an input that would have been accepted.
        in_valid = 1'b1;
        in_data  = word_t'(32'h66);
        tick();
        flush    = 1'b1;
        in_data  = word_t'(32'h33);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("busy_flush_valid", word_t'(out_valid), '0);
        tick();
        check("busy_flush_drop", word_t'(occupancy), '0);

        // Asynchronous reset mid-cycle while FULL.
        in_valid = 1'b1;
        in_data  = word_t'(32'h77);
        tick();
        in_data  = word_t'(32'h88);
        tick();
        in_valid = 1'b0;
        check("pre_rst_occ", word_t'(occupancy), word_t'(2));
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", word_t'(out_valid), '0);
        check("async_in_ready", word_t'(in_ready), word_t'(1));
        check("async_out_data", out_data, '0);
        check("async_occ", word_t'(occupancy), '0);
        tick();
        reset = 1'b0;
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = word_t'({$urandom(), $urandom(), $urandom()});
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();

`ifdef PIPE_REG_PERF_EN
        // Counter saturation and flush counting.
        do_reset();
        in_valid = 1'b1;
        in_data  = word_t'(32'h5);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("stall_sat", word_t'(stall_cycles), word_t'(15));
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
        end
        check("flush_count3", word_t'(flush_count), word_t'(3));
`else
        do_reset();
        check("final_rst_occ", word_t'(occupancy), '0);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
